switch_allocator: RTL

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/noc_alloc_pkg.sv | 21 ++
 rtl/rr_pick.sv | 39 +++
 rtl/switch_allocator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/noc_alloc_pkg.sv
// -----------------------------------------------------------------------------
// noc_alloc_pkg
// Shared types and constants for the NoC switch allocator.
//   alloc_state_t : per-output lock state (IDLE, LOCKED)
//   LOCAL/NORTH/SOUTH/EAST/WEST : router port indices, the same for inputs
//                                 and outputs of the crossbar
// -----------------------------------------------------------------------------
package noc_alloc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: scans the request vector starting at the
// pointer position, wraps modulo CHANNEL_NUMBER (which need not be a power of
// two), skips any masked entry and returns the first hit.
// Ports:
//   req   : one request bit per input
//   ptr   : index with the highest priority this cycle
//   excl  : inputs that may not win this cycle
//   valid : at least one eligible requester
//   idx   : index of the winner (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  logic [CHANNEL_NUMBER-1:0]       req,
    input  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr,
    input  logic [CHANNEL_NUMBER-1:0]       excl,
    output logic                            valid,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] idx
);

    logic [CHANNEL_NUMBER_WIDTH-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < CHANNEL_NUMBER; k++) begin
            cand = CHANNEL_NUMBER_WIDTH'((int'(ptr) + k) % CHANNEL_NUMBER);
            if (!valid && req[cand] && !excl[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
// Packet-granular output allocator for a CHANNEL_NUMBER x CHANNEL_NUMBER
// crossbar. Each output owns an IDLE/LOCKED FSM: an idle output grants one of
// its requesters round-robin, then stays locked to that owner until the owner
// hands over its last beat. On that release cycle the next requester (never
// the releasing input) is loaded directly, so back-to-back packets from
// different inputs see no bubble.
//
// Optional build macro: SWITCH_ALLOC_WATCHDOG_EN
//   Adds a per-output stall counter; an owner that makes no progress for
//   TIMEOUT_CYCLES cycles is force-released and timeout_o[j] pulses once.
//   Without the macro there are no counters and timeout_o is tied to 0.
//
// Ports:
//   clk_i        : clock
//   rst_n_i      : asynchronous active-low reset
//   req_valid_i  : input i has a packet head or beats pending
//   req_port_i   : output port requested by input i
//   fire_i       : handshake on input i this cycle
//   last_i       : beat on input i is the last of its packet
//   out_valid_o  : output j is locked to an owner
//   out_sel_o    : owner input of output j (crossbar select)
//   in_grant_o   : input i currently owns some output
//   timeout_o    : one-cycle pulse when output j is force-released
// -----------------------------------------------------------------------------
module switch_allocator
    import noc_alloc_pkg::*;
#(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int TIMEOUT_CYCLES       = 256
) (
    input  logic                                                clk_i,
    input  logic                                                rst_n_i,
    input  logic [CHANNEL_NUMBER-1:0]                           req_valid_i,
    input  logic [CHANNEL_NUMBER-1:0][CHANNEL_NUMBER_WIDTH-1:0] req_port_i,
    input  logic [CHANNEL_NUMBER-1:0]                           fire_i,
    input  logic [CHANNEL_NUMBER-1:0]                           last_i,
    output logic [CHANNEL_NUMBER-1:0]                           out_valid_o,
    output logic [CHANNEL_NUMBER-1:0][CHANNEL_NUMBER_WIDTH-1:0] out_sel_o,
    output logic [CHANNEL_NUMBER-1:0]                           in_grant_o,
    output logic [CHANNEL_NUMBER-1:0]                           timeout_o
);

    alloc_state_t                    state_q [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER_WIDTH-1:0] sel_q   [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_q   [CHANNEL_NUMBER];

    logic [CHANNEL_NUMBER-1:0]       pick_vld;
    logic [CHANNEL_NUMBER_WIDTH-1:0] pick_idx [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0]       fire_own;
    logic [CHANNEL_NUMBER-1:0]       release_now;
    logic [CHANNEL_NUMBER-1:0]       timeout_hit;

    // Pointer advance past the winner, wrapping at CHANNEL_NUMBER-1.
    function automatic logic [CHANNEL_NUMBER_WIDTH-1:0] wrap_inc(
        input logic [CHANNEL_NUMBER_WIDTH-1:0] idx
    );
        return (idx == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1)) ? '0 : idx + 1'b1;
    endfunction

    // in_grant_o comes only from registered state, so it never loops back
    // into the request qualification combinationally.
    always_comb begin
        in_grant_o = '0;
        for (int j = 0; j < CHANNEL_NUMBER; j++) begin
            if (state_q[j] == LOCKED) begin
                in_grant_o[sel_q[j]] = 1'b1;
            end
        end
    end

    // ---- request qualification and arbitration, one picker per output ----
    for (genvar j = 0; j < CHANNEL_NUMBER; j++) begin : g_out
        logic [CHANNEL_NUMBER-1:0] req_vec;
        logic [CHANNEL_NUMBER-1:0] excl;

        // Out-of-range port numbers never match any j, so they drop out here.
        always_comb begin
            req_vec = '0;
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                req_vec[i] = req_valid_i[i]
                           && (req_port_i[i] == CHANNEL_NUMBER_WIDTH'(j))
                           && !in_grant_o[i];
            end
        end

        assign excl = (state_q[j] == LOCKED) ? (CHANNEL_NUMBER'(1) << sel_q[j]) : '0;

        // Handshakes from non-owners are ignored by indexing with the owner.
        assign fire_own[j]    = (state_q[j] == LOCKED) && fire_i[sel_q[j]];
        assign release_now[j] = (fire_own[j] && last_i[sel_q[j]]) || timeout_hit[j];

        rr_pick #(
            .CHANNEL_NUMBER       (CHANNEL_NUMBER),
            .CHANNEL_NUMBER_WIDTH (CHANNEL_NUMBER_WIDTH)
        ) u_pick (
            .req   (req_vec),
            .ptr   (ptr_q[j]),
            .excl  (excl),
            .valid (pick_vld[j]),
            .idx   (pick_idx[j])
        );

        assign out_valid_o[j] = (state_q[j] == LOCKED);
        assign out_sel_o[j]   = sel_q[j];
    end

    // ---- per-output lock FSM ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < CHANNEL_NUMBER; j++) begin
                state_q[j] <= IDLE;
                sel_q[j]   <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < CHANNEL_NUMBER; j++) begin
                // A releasing output re-arbitrates in the same cycle, which
                // gives the zero-bubble handover.
                if (state_q[j] == IDLE || release_now[j]) begin
                    if (pick_vld[j]) begin
                        state_q[j] <= LOCKED;
                        sel_q[j]   <= pick_idx[j];
                        ptr_q[j]   <= wrap_inc(pick_idx[j]);
                    end else begin
                        state_q[j] <= IDLE;
                    end
                end
            end
        end
    end

`ifdef SWITCH_ALLOC_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]          stall_q [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] timeout_q;

    // Fires on the cycle that would take the count to TIMEOUT_CYCLES, so the
    // pulse appears exactly TIMEOUT_CYCLES edges after the last progress.
    always_comb begin
        timeout_hit = '0;
        for (int j = 0; j < CHANNEL_NUMBER; j++) begin
            timeout_hit[j] = (state_q[j] == LOCKED) && !fire_own[j]
                           && (stall_q[j] == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // ---- stall watchdog ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timeout_q <= '0;
            for (int j = 0; j < CHANNEL_NUMBER; j++) begin
                stall_q[j] <= '0;
            end
        end else begin
            timeout_q <= timeout_hit;
            for (int j = 0; j < CHANNEL_NUMBER; j++) begin
                if (state_q[j] == IDLE || fire_own[j] || release_now[j]) begin
                    stall_q[j] <= '0;
                end else begin
                    stall_q[j] <= stall_q[j] + 1'b1;
                end
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = '0;
    assign timeout_o   = '0;
`endif

endmodule
